lp805x_ntmr_sched: RTL and testbench

- Four-channel compare scheduler that shares the single 16-bit new-timer count among four virtual timers.
- Each channel holds a 16-bit compare value and a 16-bit period.
  - A match sets the channel's pending flag.
  - In periodic mode, a match also re-arms the compare value by adding the period.
- Pending channels are arbitrated round-robin onto one interrupt request and one vector register.
- The block is an SFR peripheral on the lp805x SFR bus, next to the new timer, and reads the timer's count directly.

---
 rtl/lp805x_ntmr_sched_pkg.sv | 35 +++
 rtl/lp805x_ntmr_sched_if.sv | 23 ++
 rtl/lp805x_ntmr_rr_arb.sv | 32 +++
 rtl/lp805x_ntmr_sched.sv | 174 +++++++++++++++++
 tb/tb_lp805x_ntmr_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lp805x_ntmr_sched_pkg.sv
// Shared definitions for the lp805x new-timer compare scheduler:
// channel count and widths, register reset values, SFR addresses,
// the NSCPND bit-address prefix and NSCSEL field positions.
package lp805x_ntmr_sched_pkg;

  localparam int CH_NUM     = 4;
  localparam int CNT_BITLEN = 16;

  typedef logic [CNT_BITLEN-1:0] cnt_t;

  localparam cnt_t CMP_RSTVAL = 16'hffff;
  localparam cnt_t PER_RSTVAL = 16'h0000;

  // SFR byte addresses
  localparam logic [7:0] NSCSEL = 8'hEC;
  localparam logic [7:0] NSCDH  = 8'hED;
  localparam logic [7:0] NSCDL  = 8'hEE;
  localparam logic [7:0] NSCCTL = 8'hEF;
  localparam logic [7:0] NSCPND = 8'hF8;
  localparam logic [7:0] NSCVEC = 8'hF9;

  // Bit address = {byte prefix, bit index}; NSCPND lives at 0xF8..0xFF
  localparam logic [4:0] NSCPND_BIT_PFX = 5'b11111;

  // NSCSEL fields
  localparam int SEL_CH_LSB  = 0;
  localparam int SEL_CH_MSB  = 1;
  localparam int SEL_TGT_BIT = 2;

  typedef enum logic {
    TGT_CMP = 1'b0,
    TGT_PER = 1'b1
  } tgt_e;

endpackage

// File: rtl/lp805x_ntmr_sched_if.sv
// SFR request side of the lp805x bus as seen by the compare scheduler.
//   wr/wr_bit/wr_addr/data_in/bit_in : byte or bit write
//   rd/rd_bit/rd_addr                : byte or bit read request
// The tri-state read returns stay plain ports on the peripheral because
// they are wired-OR'd with every other SFR block on the bus.
interface lp805x_ntmr_sched_if;
  logic       wr;
  logic       wr_bit;
  logic       rd;
  logic       rd_bit;
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] data_in;
  logic       bit_in;

  modport master (
    output wr, wr_bit, rd, rd_bit, wr_addr, rd_addr, data_in, bit_in
  );

  modport slave (
    input wr, wr_bit, rd, rd_bit, wr_addr, rd_addr, data_in, bit_in
  );
endinterface

// File: rtl/lp805x_ntmr_rr_arb.sv
// Combinational 4-input round-robin arbiter.
//   req : request vector
//   lp  : last granted index; scanning starts at lp+1 and wraps
//   idx : granted index (0 when nothing is requested)
//   vld : at least one request present
module lp805x_ntmr_rr_arb
  import lp805x_ntmr_sched_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [1:0]        lp,
  output logic [1:0]        idx,
  output logic              vld
);

  logic [1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a latch is inferred.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      cand = lp + 2'(k);
      if (!vld && req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lp805x_ntmr_sched.sv
// Four-channel compare scheduler sharing the new-timer count.
//   clk, rst     : clock, asynchronous active-high reset
//   sfr          : SFR write/read requests
//   data_out     : registered byte read data, z when not addressed
//   bit_out      : registered NSCPND bit read data, z otherwise
//   tmr_count    : live count from the new timer
//   int_req      : |(pend & en)
//   int_vec      : currently granted channel
module lp805x_ntmr_sched
  import lp805x_ntmr_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  lp805x_ntmr_sched_if.slave  sfr,
  output tri   [7:0]          data_out,
  output tri                  bit_out,
  input  cnt_t                tmr_count,
  output logic                int_req,
  output logic [1:0]          int_vec
);

  logic [1:0]               sel_ch_q;
  tgt_e                     sel_tgt_q;
  logic [7:0]               stage_q;
  logic [CH_NUM-1:0]        en_q, prd_q, pend_q;
  logic [CH_NUM-1:0][CNT_BITLEN-1:0] cmp_q, per_q;
  cnt_t                     cnt_q;
  logic                     gnt_q;
  logic [1:0]               lp_q;

  logic                     wr_byte, wr_pbit, commit;
  logic [CH_NUM-1:0]        hit, req, pend_nx;
  cnt_t                     sel_val, commit_val;
  logic [1:0]               arb_lp, arb_idx;
  logic                     arb_vld;
  logic                     rd_hit_nx, rd_hit_q, bit_hit_nx, bit_hit_q, bit_val_nx, bit_val_q;
  logic [7:0]               rd_data_nx, rd_data_q;

  // Reads decode on rd_addr alone; the strobe carries no extra information.
  logic unused_rd;
  assign unused_rd = sfr.rd;

  assign wr_byte    = sfr.wr && !sfr.wr_bit;
  assign wr_pbit    = sfr.wr && sfr.wr_bit && (sfr.wr_addr[7:3] == NSCPND_BIT_PFX);
  assign commit     = wr_byte && (sfr.wr_addr == NSCDL);
  assign commit_val = {stage_q, sfr.data_in};
  assign sel_val    = (sel_tgt_q == TGT_PER) ? per_q[sel_ch_q] : cmp_q[sel_ch_q];

  // A match needs the count to have moved this cycle, so a stalled timer
  // fires once and a timer that skips over cmp never fires.
  always_comb begin
    hit = '0;
    for (int i = 0; i < CH_NUM; i++)
      hit[i] = en_q[i] && (tmr_count != cnt_q) && (tmr_count == cmp_q[i]);
  end

  // Software write first, hardware set last so a match beats a clear.
  always_comb begin
    pend_nx = pend_q;
    if (wr_byte && (sfr.wr_addr == NSCPND)) pend_nx = sfr.data_in[CH_NUM-1:0];
    if (wr_pbit && !sfr.wr_addr[2])         pend_nx[sfr.wr_addr[1:0]] = sfr.bit_in;
    pend_nx = pend_nx | hit;
  end

  assign req     = pend_q & en_q;
  assign int_req = |req;

  // While a grant is held the scan starts after it, which is exactly the
  // pointer value the release would store.
  assign arb_lp = gnt_q ? int_vec : lp_q;

  lp805x_ntmr_rr_arb u_arb (
    .req (req),
    .lp  (arb_lp),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // NOTE: the compare/period register file is reset like any other flop;
  // software relies on the documented reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ch_q  <= '0;
      sel_tgt_q <= TGT_CMP;
      stage_q   <= '0;
      en_q      <= '0;
      prd_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        cmp_q[i] <= CMP_RSTVAL;
        per_q[i] <= PER_RSTVAL;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cnt_q  <= tmr_count;
      pend_q <= pend_nx;
      if (wr_byte) begin
        case (sfr.wr_addr)
          NSCSEL: begin
            sel_ch_q  <= sfr.data_in[SEL_CH_MSB:SEL_CH_LSB];
            sel_tgt_q <= tgt_e'(sfr.data_in[SEL_TGT_BIT]);
          end
          NSCDH:  stage_q <= sfr.data_in;
          NSCCTL: begin
            en_q  <= sfr.data_in[3:0];
            prd_q <= sfr.data_in[7:4];
          end
          default: ;
        endcase
      end
      for (int i = 0; i < CH_NUM; i++)
        if (hit[i] && prd_q[i]) cmp_q[i] <= cmp_q[i] + per_q[i];
      // NOTE: this commit follows the re-arm above; the later non-blocking
      // assignment to the same flop wins, giving software priority.
      if (commit) begin
        if (sel_tgt_q == TGT_PER) per_q[sel_ch_q] <= commit_val;
        else                      cmp_q[sel_ch_q] <= commit_val;
      end
    end
  end

  // Grant is held while its channel stays pending and enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= 1'b0;
      lp_q    <= 2'd3;
      int_vec <= '0;
    end else if (!gnt_q || !req[int_vec]) begin
      if (gnt_q) lp_q <= int_vec;
      gnt_q <= arb_vld;
      if (arb_vld) int_vec <= arb_idx;
    end
  end

  always_comb begin
    rd_hit_nx  = 1'b0;
    rd_data_nx = '0;
    if (!sfr.rd_bit) begin
      rd_hit_nx = 1'b1;
      case (sfr.rd_addr)
        NSCSEL:  rd_data_nx = {5'b0, sel_tgt_q, sel_ch_q};
        NSCDH:   rd_data_nx = sel_val[15:8];
        NSCDL:   rd_data_nx = sel_val[7:0];
        NSCCTL:  rd_data_nx = {prd_q, en_q};
        NSCPND:  rd_data_nx = {4'b0, pend_q};
        NSCVEC:  rd_data_nx = {int_req, 5'b0, int_vec};
        default: rd_hit_nx  = 1'b0;
      endcase
    end
  end

  assign bit_hit_nx = sfr.rd_bit && (sfr.rd_addr[7:3] == NSCPND_BIT_PFX);
  assign bit_val_nx = !sfr.rd_addr[2] && pend_q[sfr.rd_addr[1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
      bit_hit_q <= 1'b0;
      bit_val_q <= 1'b0;
    end else begin
      rd_hit_q  <= rd_hit_nx;
      rd_data_q <= rd_data_nx;
      bit_hit_q <= bit_hit_nx;
      bit_val_q <= bit_val_nx;
    end
  end

  assign data_out = rd_hit_q  ? rd_data_q : 8'bz;
  assign bit_out  = bit_hit_q ? bit_val_q : 1'bz;

endmodule

// File: tb/tb_lp805x_ntmr_sched.sv
// Directed bench for the lp805x compare scheduler. Inputs change 1 ns
// after a rising edge; outputs are sampled there too, well clear of edges.
module tb_lp805x_ntmr_sched;
  import lp805x_ntmr_sched_pkg::*;

  logic       clk;
  logic       rst;
  cnt_t       tmr_count;
  wire  [7:0] data_out;
  wire        bit_out;
  logic       int_req;
  logic [1:0] int_vec;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  lp805x_ntmr_sched_if bus ();

  lp805x_ntmr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .sfr       (bus),
    .data_out  (data_out),
    .bit_out   (bit_out),
    .tmr_count (tmr_count),
    .int_req   (int_req),
    .int_vec   (int_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    bus.wr = 1'b1; bus.wr_bit = 1'b0; bus.wr_addr = a; bus.data_in = d;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic bit_wr(input logic [7:0] a, input logic b);
    bus.wr = 1'b1; bus.wr_bit = 1'b1; bus.wr_addr = a; bus.bit_in = b;
    tick();
    bus.wr = 1'b0; bus.wr_bit = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus.rd = 1'b1; bus.rd_bit = 1'b0; bus.rd_addr = a;
    tick();
    d = data_out;
    bus.rd = 1'b0; bus.rd_addr = 8'h00;
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic bit_check(input string tag, input logic [7:0] a, input logic exp);
    logic b;
    bus.rd = 1'b1; bus.rd_bit = 1'b1; bus.rd_addr = a;
    tick();
    b = bit_out;
    bus.rd = 1'b0; bus.rd_bit = 1'b0; bus.rd_addr = 8'h00;
    check(tag, {15'h0, b}, {15'h0, exp});
  endtask

  initial begin
    rst = 1'b1; tmr_count = '0;
    bus.wr = 1'b0; bus.wr_bit = 1'b0; bus.rd = 1'b0; bus.rd_bit = 1'b0;
    bus.wr_addr = 8'h00; bus.rd_addr = 8'h00; bus.data_in = 8'h00; bus.bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_int_req", {15'h0, int_req}, 16'h0);
    check("rst_int_vec", {14'h0, int_vec}, 16'h0);
    rd_check("rst_sel", NSCSEL, 8'h00);
    rd_check("rst_ctl", NSCCTL, 8'h00);
    rd_check("rst_pnd", NSCPND, 8'h00);
    rd_check("rst_vec", NSCVEC, 8'h00);
    rd_check("rst_cmp0_lo", NSCDL, 8'hff);
    rd_check("rst_cmp0_hi", NSCDH, 8'hff);

    // Basic one-shot match on ch0 at 0x1234
    sfr_wr(NSCSEL, 8'h00);
    sfr_wr(NSCDH, 8'h12);
    sfr_wr(NSCDL, 8'h34);
    sfr_wr(NSCCTL, 8'h01);
    tmr_count = 16'h1233; tick();
    tmr_count = 16'h1234;
    check("match_not_yet", {15'h0, int_req}, 16'h0);
    tick();
    check("match_int_req", {15'h0, int_req}, 16'h1);
    rd_check("match_vec", NSCVEC, 8'h80);
    rd_check("match_pnd", NSCPND, 8'h01);
    bit_check("match_pnd_bit0", 8'hF8, 1'b1);
    bit_check("match_pnd_bit1", 8'hF9, 1'b0);
    rd_check("cmp0_lo", NSCDL, 8'h34);
    rd_check("cmp0_hi", NSCDH, 8'h12);

    // High byte alone only stages; low byte commits atomically
    sfr_wr(NSCDH, 8'hAB);
    rd_check("stage_lo_unchg", NSCDL, 8'h34);
    rd_check("stage_hi_unchg", NSCDH, 8'h12);
    sfr_wr(NSCDL, 8'hCD);
    rd_check("commit_lo", NSCDL, 8'hCD);
    rd_check("commit_hi", NSCDH, 8'hAB);
    sfr_wr(NSCPND, 8'h00);
    check("clr_int_req", {15'h0, int_req}, 16'h0);

    // Periodic ch1: 0xFFF0 + 0x0020 wraps to 0x0010
    sfr_wr(NSCSEL, 8'h01);
    sfr_wr(NSCDH, 8'hFF);
    sfr_wr(NSCDL, 8'hF0);
    sfr_wr(NSCSEL, 8'h05);
    sfr_wr(NSCDH, 8'h00);
    sfr_wr(NSCDL, 8'h20);
    rd_check("per1_lo", NSCDL, 8'h20);
    sfr_wr(NSCSEL, 8'h01);
    sfr_wr(NSCCTL, 8'h22);
    tmr_count = 16'hFFEF; tick();
    tmr_count = 16'hFFF0; tick();
    rd_check("per_pnd1", NSCPND, 8'h02);
    rd_check("per_wrap_lo", NSCDL, 8'h10);
    rd_check("per_wrap_hi", NSCDH, 8'h00);
    sfr_wr(NSCPND, 8'h00);
    tmr_count = 16'h0010; tick();
    rd_check("per_pnd1_again", NSCPND, 8'h02);
    rd_check("per_rearm_lo", NSCDL, 8'h30);

    // Stalled timer on ch2 matches only once
    sfr_wr(NSCSEL, 8'h02);
    sfr_wr(NSCDH, 8'h05);
    sfr_wr(NSCDL, 8'h00);
    sfr_wr(NSCCTL, 8'h04);
    sfr_wr(NSCPND, 8'h00);
    tmr_count = 16'h0500;
    repeat (10) tick();
    rd_check("stall_pnd2", NSCPND, 8'h04);
    bit_wr(8'hFA, 1'b0);
    repeat (3) tick();
    rd_check("stall_no_reset", NSCPND, 8'h00);

    // Hardware set beats software bit clear
    sfr_wr(NSCSEL, 8'h01);
    sfr_wr(NSCCTL, 8'h22);
    bit_wr(8'hF9, 1'b1);
    rd_check("sw_set_pnd1", NSCPND, 8'h02);
    tmr_count = 16'h0030;
    bit_wr(8'hF9, 1'b0);
    rd_check("set_wins_pnd", NSCPND, 8'h02);
    rd_check("set_wins_rearm", NSCDL, 8'h50);

    // Software commit beats periodic re-arm; pending still recorded
    sfr_wr(NSCPND, 8'h00);
    sfr_wr(NSCDH, 8'h77);
    tmr_count = 16'h0050;
    sfr_wr(NSCDL, 8'h88);
    rd_check("sw_wins_pnd", NSCPND, 8'h02);
    rd_check("sw_wins_lo", NSCDL, 8'h88);
    rd_check("sw_wins_hi", NSCDH, 8'h77);

    // Asynchronous reset mid-operation
    check("pre_rst_int_req", {15'h0, int_req}, 16'h1);
    rst = 1'b1;
    #1;
    check("async_rst_int_req", {15'h0, int_req}, 16'h0);
    tick(); tick();
    rst = 1'b0;
    rd_check("rst2_ctl", NSCCTL, 8'h00);
    rd_check("rst2_pnd", NSCPND, 8'h00);
    rd_check("rst2_sel", NSCSEL, 8'h00);
    rd_check("rst2_cmp0_lo", NSCDL, 8'hff);
    sfr_wr(NSCSEL, 8'h01);
    rd_check("rst2_cmp1_hi", NSCDH, 8'hff);
    sfr_wr(NSCSEL, 8'h05);
    rd_check("rst2_per1_lo", NSCDL, 8'h00);

    // Round-robin: ch0 and ch3 pending together
    sfr_wr(NSCCTL, 8'h09);
    sfr_wr(NSCPND, 8'h09);
    tick();
    check("rr_first", {14'h0, int_vec}, 16'h0);
    bit_wr(8'hF8, 1'b0);
    tick();
    check("rr_next3", {14'h0, int_vec}, 16'h3);
    bit_wr(8'hF8, 1'b1);
    tick();
    check("rr_hold3", {14'h0, int_vec}, 16'h3);
    bit_wr(8'hFB, 1'b0);
    tick();
    check("rr_wrap0", {14'h0, int_vec}, 16'h0);
    rd_check("rr_vec_rd", NSCVEC, 8'h80);

    // Disabling masks the request but keeps the pending bit
    sfr_wr(NSCCTL, 8'h08);
    check("dis_int_req", {15'h0, int_req}, 16'h0);
    rd_check("dis_pnd_kept", NSCPND, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
